// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Included by the arbiter RTL and by its testbench.
package mem_arb_pkg;

  localparam int ADDR_W_DEF         = 16;
  localparam int DATA_W_DEF         = 16;
  localparam int FETCH_MAX_WAIT_DEF = 3;
  localparam int CNT_W_DEF          = 16;
  // Starvation counter width; FETCH_MAX_WAIT is limited to 1..15
  localparam int WAIT_W             = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: data requester has priority, except that the
// fetch requester wins once it has lost FETCH_MAX_WAIT contended arbitrations.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int FETCH_MAX_WAIT = FETCH_MAX_WAIT_DEF
) (
  input  logic              i_req,
  input  logic              d_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              grant_i,
  output logic              grant_d,
  output logic [WAIT_W-1:0] wait_cnt_next
);

  logic fetch_due;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    wait_cnt_next = wait_cnt;
    fetch_due     = (wait_cnt == WAIT_W'(FETCH_MAX_WAIT));

    grant_i = i_req && (!d_req || fetch_due);
    grant_d = d_req && !grant_i;

    if (grant_i) begin
      wait_cnt_next = '0;
    end else if (grant_d && i_req) begin
      wait_cnt_next = wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D),
// one outstanding transaction at a time, with a contention-cycle counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int FETCH_MAX_WAIT = FETCH_MAX_WAIT_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              grant_i, grant_d;

  arb_pick #(
    .FETCH_MAX_WAIT(FETCH_MAX_WAIT)
  ) u_pick (
    .i_req         (i_req),
    .d_req         (d_req),
    .wait_cnt      (wait_cnt),
    .grant_i       (grant_i),
    .grant_d       (grant_d),
    .wait_cnt_next (wait_cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Acks are gated by reset so a transaction cut short by reset never completes
  always_comb begin
    state_d = state_q;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_i)      state_d = ARB_BUSY_I;
        else if (grant_d) state_d = ARB_BUSY_D;
      end
      ARB_BUSY_I: begin
        i_ack = mem_ready && !reset;
        if (mem_ready) state_d = ARB_IDLE;
      end
      ARB_BUSY_D: begin
        d_ack = mem_ready && !reset;
        if (mem_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (i_ack)            i_rdata = mem_rdata;
    if (d_ack && !mem_we) d_rdata = mem_rdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      wait_cnt       <= '0;
      contention_cnt <= '0;
    end else if (state_q == ARB_IDLE) begin
      wait_cnt <= wait_cnt_next;
      if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
      if (i_req && d_req && (contention_cnt != '1)) begin
        contention_cnt <= contention_cnt + CNT_W'(1);
      end
    end else if (mem_ready) begin
      mem_req <= 1'b0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the CPU's instruction-fetch requester (I) and its load/store requester (D).
- Sits between the cpu_top fetch/memory stages and the memory model.
- Grants one outstanding transaction at a time, using fixed D-priority with a fetch anti-starvation limit.
- Forwards the memory's variable-latency ready/rdata handshake back to the granted requester and counts contention cycles for performance reporting.

Parameters:
- ADDR_W, 16, word-address width.
- DATA_W, 16, data word width.
- FETCH_MAX_WAIT, 3, consecutive lost arbitrations after which I wins; legal range 1..15.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle completion pulse for fetch
- i_rdata  out  DATA_W  fetch data; valid only while i_ack=1
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data; valid only while d_ack=1
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ready  in  1  memory completes the transaction this cycle (sampled only while mem_req=1)
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- contention_cnt  out  CNT_W  cycles in IDLE with both i_req and d_req high; saturates at all-ones

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_req, mem_we, i_ack and d_ack are 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata and contention_cnt are 0.
  - The starvation counter wait_cnt is 0.
- States:
  - IDLE: arbitrate on the current cycle's req inputs.
  - BUSY_I: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- IDLE arbitration:
  - Only d_req: go to BUSY_D.
  - Only i_req: go to BUSY_I.
  - Both requests and wait_cnt==FETCH_MAX_WAIT: go to BUSY_I and clear wait_cnt.
  - Both requests and wait_cnt<FETCH_MAX_WAIT: go to BUSY_D and increment wait_cnt.
  - Any grant to I clears wait_cnt.
  - Neither request: stay in IDLE.
- On grant (edge leaving IDLE):
  - Register mem_addr, mem_we and mem_wdata from the winner.
  - A fetch grant forces mem_we=0 and mem_wdata=0.
  - mem_req=1 from the next cycle.
- BUSY_x:
  - mem_req and the payload are held stable until a cycle with mem_ready=1.
  - In that cycle, x_ack=1 and x_rdata=mem_rdata; both are combinational from mem_ready/mem_rdata, gated by state.
  - The next edge returns to IDLE with mem_req=0.
  - On a store ack, d_rdata is 0.
- Latency:
  - The request is sampled at edge N; mem_req is high during cycle N+1.
  - With mem_ready=1 in that cycle, ack is in cycle N+1.
  - Minimum spacing is one transaction per 2 cycles, because of the mandatory IDLE cycle.
- A requester that keeps req high in the cycle after its ack is treated as a new request.
- A requester dropping req while BUSY is a protocol violation:
  - The transaction completes anyway and the ack still pulses.
  - A bench assertion flags it.
- Acks are mutually exclusive; never both in one cycle.
- contention_cnt increments on every IDLE cycle with both requests high and saturates at 2^CNT_W-1; it has no wrap.
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-transaction:
  - At that edge mem_req drops and no ack is issued.
  - The memory abandons the request.
  - The counters clear.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D};
  - typedef mem_req_t, a struct of we/addr/wdata;
  - the default widths as localparams.
- One natural sub-module: arb_pick. It is the combinational winner-select plus the wait_cnt next-value logic, unit-testable alone.
- The FSM, payload registers and counter stay in the top.

Test Plan:
- Fetch only:
  - Stimulus: i_req, i_addr=0x0004, mem_ready=1 immediately, mem_rdata=0x2224.
  - Response: mem_addr=0x0004, mem_we=0; i_ack one cycle after grant with i_rdata=0x2224; d_ack never high.
- Store then load:
  - Stimulus: d_req, we=1, addr=0x0100, wdata=0xBEEF, mem_ready delayed 3 cycles.
  - Response: mem_req and payload held 4 cycles; d_ack single pulse.
  - Then a load from 0x0100 with mem_rdata=0xBEEF gives d_rdata=0xBEEF.
- Continuous contention:
  - Stimulus: i_req and d_req held high throughout, FETCH_MAX_WAIT=3, mem_ready=1.
  - Response: grant order D,D,D,I,D,D,D,I; contention_cnt=8 after 8 grants.
- Variable latency:
  - Stimulus: mem_ready pattern 0,0,1 on a fetch.
  - Response: i_ack only in the mem_ready cycle; mem_ready=1 while IDLE produces no ack.
- Reset mid-transaction:
  - Stimulus: reset asserted during BUSY_D before mem_ready.
  - Response: next cycle mem_req=0, no d_ack, contention_cnt=0, state IDLE; a fetch after release completes normally.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 contention cycles.
  - Response: contention_cnt=0xF and stays at 0xF.
